// File: rtl/wi23_defs_pkg.sv
// Shared EX-stage definitions: register width plus the mul/div sequencer's op and state encodings.
package wi23_defs;

  localparam int REGFILE_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the shared {acc,lo} working pair.
module muldiv_step
  import wi23_defs::*;
#(
  parameter int WIDTH = REGFILE_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  // acc[WIDTH] is always 0 in multiply mode, so the add never overflows WIDTH+1 bits
  assign sum   = acc + (lo[0] ? {1'b0, opnd} : '0);
  assign r_sh  = {acc[WIDTH-1:0], lo[WIDTH-1]};
  assign trial = r_sh - {1'b0, opnd};

  always_comb begin
    acc_next = {1'b0, sum[WIDTH:1]};
    lo_next  = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_next = trial;
        lo_next  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = r_sh;
        lo_next  = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit with request and response valid/ready handshakes.
//   state   | meaning
//   MD_IDLE | ready for a request
//   MD_BUSY | iterating, one step per cycle
//   MD_DONE | result held until resp_ready
module muldiv_seq
  import wi23_defs::*;
#(
  parameter int WIDTH = REGFILE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_dbz,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t   state, state_next;
  muldiv_op_t      op_q, op_in;
  logic [CW-1:0]   count;
  logic [WIDTH:0]  acc, acc_next;
  logic [WIDTH-1:0] lo, lo_next, opnd;
  logic            accept, in_div, in_dbz, last_step, op_div, lo_result;

  assign op_in     = muldiv_op_t'(req_op);
  assign req_ready = (state == MD_IDLE);
  assign busy      = (state != MD_IDLE);
  assign accept    = req_valid && req_ready;
  assign in_div    = (op_in == MD_DIVU) || (op_in == MD_REMU);
  assign in_dbz    = in_div && (req_b == '0);
  assign op_div    = (op_q == MD_DIVU) || (op_q == MD_REMU);
  assign lo_result = (op_q == MD_MUL) || (op_q == MD_DIVU);
  assign last_step = (state == MD_BUSY) && (count == CW'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_div),
    .acc      (acc),
    .lo       (lo),
    .opnd     (opnd),
    .acc_next (acc_next),
    .lo_next  (lo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (accept) state_next = in_dbz ? MD_DONE : MD_BUSY;
        MD_BUSY: if (last_step) state_next = MD_DONE;
        MD_DONE: if (resp_ready) state_next = MD_IDLE;
        default: state_next = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      op_q       <= MD_MUL;
      count      <= '0;
      acc        <= '0;
      lo         <= '0;
      opnd       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_dbz   <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            count <= '0;
            acc   <= '0;
            // multiply keeps the multiplier in lo; divide keeps the dividend there as Q
            lo    <= in_div ? req_a : req_b;
            opnd  <= in_div ? req_b : req_a;
            if (in_dbz) begin
              resp_valid <= 1'b1;
              resp_dbz   <= 1'b1;
              resp_data  <= (op_in == MD_DIVU) ? '1 : req_a;
            end
          end
        end
        MD_BUSY: begin
          acc   <= acc_next;
          lo    <= lo_next;
          count <= count + CW'(1);
          if (last_step) begin
            resp_valid <= 1'b1;
            resp_dbz   <= 1'b0;
            resp_data  <= lo_result ? lo_next : acc_next[WIDTH-1:0];
          end
        end
        MD_DONE: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: randomized and directed requests against an arithmetic reference.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready, resp_dbz, busy;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b, resp_data;

  typedef struct {
    logic [31:0] data;
    logic        dbz;
    int          acc_cyc;
    int          lat;
    int          hold;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_dbz   (resp_dbz),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    p   = {32'b0, a} * {32'b0, b};
    e.dbz = 1'b0;
    e.lat = 33;
    e.acc_cyc = 0;
    e.hold = 0;
    case (op)
      2'd0: e.data = p[31:0];
      2'd1: e.data = p[63:32];
      2'd2: e.data = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: e.data = (b == 0) ? a : a % b;
    endcase
    if (op[1] && b == 0) begin
      e.dbz = 1'b1;
      e.lat = 1;
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit expect_resp);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    if (expect_resp) begin
      e         = model(op, a, b);
      e.acc_cyc = cyc;
      e.hold    = hold;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0 || resp_valid || !req_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", q.size(), 0);
    @(negedge clk);
  endtask

  // Consumer: pops the expectation on the first valid cycle, applies backpressure, then accepts.
  initial begin
    exp_t e;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_resp: resp_valid=1 data=%0h, required no response", resp_data);
          resp_ready = 1'b1;
          @(negedge clk);
          resp_ready = 1'b0;
        end else begin
          e = q.pop_front();
          check("latency", cyc - e.acc_cyc, e.lat);
          check("resp_data", resp_data, e.data);
          check("resp_dbz", resp_dbz, e.dbz);
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, e.data);
            check("hold_dbz", resp_dbz, e.dbz);
          end
          resp_ready = 1'b1;
          @(negedge clk);
          resp_ready = 1'b0;
          check("release_valid", resp_valid, 0);
          check("release_req_ready", req_ready, 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_dbz", resp_dbz, 0);
    rst = 1'b0;

    issue(2'd0, 32'd7, 32'd6, 0, 1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    issue(2'd2, 32'd100, 32'd7, 2, 1);
    issue(2'd3, 32'd100, 32'd7, 0, 1);
    issue(2'd2, 32'h8000_0000, 32'd1, 0, 1);
    issue(2'd2, 32'd5, 32'd0, 3, 1);
    issue(2'd3, 32'd5, 32'd0, 0, 1);
    drain();

    // backpressure plus an ignored request pulse during BUSY
    issue(2'd2, 32'd100, 32'd7, 5, 1);
    repeat (3) @(negedge clk);
    check("busy_req_ready", req_ready, 0);
    check("busy_flag", busy, 1);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd1; req_b = 32'd1;
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // flush mid-divide, then reset mid-multiply: neither may respond
    issue(2'd2, 32'd12345, 32'd17, 0, 0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_req_ready", req_ready, 1);
    check("flush_resp_valid", resp_valid, 0);
    issue(2'd0, 32'd9, 32'd9, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_data", resp_data, 0);
    repeat (40) @(negedge clk);
    issue(2'd0, 32'd3, 32'd4, 0, 1);
    drain();

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      issue(op, a, b, $urandom_range(0, 3), 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
